// File: rtl/range_list_writer_pkg.sv
// Range-list format constants, BCD digit types and writer FSM states.
// Shared with the solver-side parser so both agree on the byte format.
package range_list_writer_pkg;

    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_EOT   = 8'h04;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int BCD_DIGITS_DEFAULT = 13;

    typedef logic [3:0] BcdDigit_t;
    typedef BcdDigit_t [BCD_DIGITS_DEFAULT-1:0] BcdArray_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CONV_START,
        S_EMIT_START,
        S_DASH,
        S_CONV_END,
        S_EMIT_END,
        S_SEP,
        S_DONE,
        S_ERROR
    } Fsm_t;

    function automatic logic [7:0] digit_to_ascii(input BcdDigit_t d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/range_list_writer_bin_to_bcd_seq.sv
// Sequential double-dabble: one shift per cycle, BIN_BITS cycles per value.
// Done pulses during the final shift; results are valid the cycle after.
module range_list_writer_bin_to_bcd_seq
    import range_list_writer_pkg::*;
#(
    parameter int BIN_BITS = 40,
    parameter int DIGITS   = 13,
    localparam int IDX_W   = $clog2(DIGITS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [BIN_BITS-1:0]     i_bin,
    output logic                    o_busy,
    output logic                    o_done,
    output BcdDigit_t [DIGITS-1:0]  o_bcd,
    output logic [IDX_W-1:0]        o_msd_idx
);

    localparam int CNT_W = $clog2(BIN_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_BITS);

    logic [BIN_BITS-1:0]    r_bin;
    BcdDigit_t [DIGITS-1:0] r_bcd;
    logic [CNT_W-1:0]       r_cnt;
    BcdDigit_t [DIGITS-1:0] w_adj;
    logic [IDX_W-1:0]       w_msd;

    // Add-3 correction on every digit that would overflow after the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i] >= 4'd5) begin
                w_adj[i] = r_bcd[i] + 4'd3;
            end
        end
    end

    // Highest nonzero digit; an all-zero value reports digit 0
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i] != 4'd0) begin
                w_msd = IDX_W'(i);
            end
        end
    end

    // Load on start, then shift binary MSB into the BCD array
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_bin <= i_bin;
            r_bcd <= '0;
            r_cnt <= CNT_LOAD;
        end else if (r_cnt != '0) begin
            r_bcd <= (4*DIGITS)'({w_adj, r_bin[BIN_BITS-1]});
            r_bin <= {r_bin[BIN_BITS-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_busy    = (r_cnt != '0);
    assign o_done    = (r_cnt == CNT_W'(1));
    assign o_bcd     = r_bcd;
    assign o_msd_idx = w_msd;

endmodule

// File: rtl/range_list_writer.sv
// Serialises {start,end} ID pairs into "s-e,s-e,...<EOT>" bytes at address 0 up.
// Optional RANGE_LIST_WRITER_ORDER_CHECK_EN: reject pairs with start > end.
module range_list_writer
    import range_list_writer_pkg::*;
#(
    parameter int ID_BITS       = 40,
    parameter int ID_MAX_DIGITS = 13,
    parameter int ADDR_WIDTH    = 16,
    parameter int MEM_DEPTH     = 65536
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [ID_BITS-1:0]    StartId,
    input  logic [ID_BITS-1:0]    EndId,
    input  logic                  InLast,
    output logic                  WrEn,
    output logic [ADDR_WIDTH-1:0] WrAddr,
    output logic [7:0]            WrData,
    output logic [ADDR_WIDTH:0]   Length,
    output logic                  Done,
    output logic                  Error
);

    localparam int IDX_W = $clog2(ID_MAX_DIGITS);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    Fsm_t                          r_state;
    Fsm_t                          w_next;
    logic [ID_BITS-1:0]            r_end_id;
    logic                          r_last;
    logic                          r_first;
    logic [IDX_W-1:0]              r_idx;
    logic                          r_in_ready;
    logic                          r_wr_en;
    logic [ADDR_WIDTH-1:0]         r_wr_addr;
    logic [7:0]                    r_wr_data;
    logic [ADDR_WIDTH:0]           r_length;
    logic                          r_done;
    logic                          r_error;

    logic                          w_wr;
    logic [7:0]                    w_byte;
    logic                          w_accept;
    logic                          w_emit_go;
    logic                          w_cv_start;
    logic [ID_BITS-1:0]            w_cv_bin;
    logic                          w_cv_busy;
    logic                          w_cv_done;
    BcdDigit_t [ID_MAX_DIGITS-1:0] w_bcd;
    logic [IDX_W-1:0]              w_msd;
    logic [IDX_W-1:0]              w_cur_idx;
    BcdDigit_t                     w_digit;
    logic                          w_full;

    range_list_writer_bin_to_bcd_seq #(
        .BIN_BITS (ID_BITS),
        .DIGITS   (ID_MAX_DIGITS)
    ) u_bcd (
        .i_clk     (Clk),
        .i_rst     (Rst),
        .i_start   (w_cv_start),
        .i_bin     (w_cv_bin),
        .o_busy    (w_cv_busy),
        .o_done    (w_cv_done),
        .o_bcd     (w_bcd),
        .o_msd_idx (w_msd)
    );

    assign w_cur_idx = r_first ? w_msd : r_idx;
    assign w_digit   = w_bcd[w_cur_idx];
    assign w_full    = (r_length == DEPTH);

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, byte to write and converter control
    always_comb begin
        w_next     = r_state;
        w_wr       = 1'b0;
        w_byte     = 8'h00;
        w_accept   = 1'b0;
        w_emit_go  = 1'b0;
        w_cv_start = 1'b0;
        w_cv_bin   = r_end_id;
        unique case (r_state)
            S_IDLE: begin
                if (InValid && r_in_ready) begin
                    w_accept = 1'b1;
`ifdef RANGE_LIST_WRITER_ORDER_CHECK_EN
                    if (StartId > EndId) begin
                        w_next = S_ERROR;
                    end else begin
                        w_next     = S_CONV_START;
                        w_cv_start = 1'b1;
                        w_cv_bin   = StartId;
                    end
`else
                    w_next     = S_CONV_START;
                    w_cv_start = 1'b1;
                    w_cv_bin   = StartId;
`endif
                end
            end
            S_CONV_START, S_CONV_END: begin
                if (w_cv_done || !w_cv_busy) begin
                    w_emit_go = 1'b1;
                    w_next    = (r_state == S_CONV_START) ? S_EMIT_START
                                                          : S_EMIT_END;
                end
            end
            S_EMIT_START, S_EMIT_END: begin
                if (w_full) begin
                    w_next = S_ERROR;
                end else begin
                    w_wr   = 1'b1;
                    w_byte = digit_to_ascii(w_digit);
                    if (w_cur_idx == '0) begin
                        w_next = (r_state == S_EMIT_START) ? S_DASH : S_SEP;
                    end
                end
            end
            S_DASH: begin
                if (w_full) begin
                    w_next = S_ERROR;
                end else begin
                    w_wr       = 1'b1;
                    w_byte     = ASCII_DASH;
                    w_cv_start = 1'b1;
                    w_next     = S_CONV_END;
                end
            end
            S_SEP: begin
                if (w_full) begin
                    w_next = S_ERROR;
                end else begin
                    w_wr   = 1'b1;
                    w_byte = r_last ? ASCII_EOT : ASCII_COMMA;
                    w_next = r_last ? S_DONE : S_IDLE;
                end
            end
            S_DONE:  w_next = S_DONE;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_IDLE;
        endcase
    end

    // Pair latch and emission digit cursor
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_end_id <= '0;
            r_last   <= 1'b0;
            r_first  <= 1'b0;
            r_idx    <= '0;
        end else begin
            if (w_accept) begin
                r_end_id <= EndId;
                r_last   <= InLast;
            end
            if (w_emit_go) begin
                r_first <= 1'b1;
            end else if (w_wr && (r_state == S_EMIT_START ||
                                  r_state == S_EMIT_END)) begin
                r_first <= 1'b0;
                r_idx   <= w_cur_idx - IDX_W'(1);
            end
        end
    end

    // Registered outputs; address and data hold between writes
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_length   <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_in_ready <= (w_next == S_IDLE);
            r_wr_en    <= w_wr;
            if (w_wr) begin
                r_wr_addr <= r_length[ADDR_WIDTH-1:0];
                r_wr_data <= w_byte;
                r_length  <= r_length + (ADDR_WIDTH+1)'(1);
            end
            r_done  <= r_done  | (w_next == S_DONE);
            r_error <= r_error | (w_next == S_ERROR);
        end
    end

    assign InReady = r_in_ready;
    assign WrEn    = r_wr_en;
    assign WrAddr  = r_wr_addr;
    assign WrData  = r_wr_data;
    assign Length  = r_length;
    assign Done    = r_done;
    assign Error   = r_error;

endmodule

// File: tb/tb_range_list_writer.sv
// Bench for range_list_writer: a full-depth and an 8-byte instance share stimulus.
// Expected byte streams come from decimal formatting of each pair.
module tb_range_list_writer;

    localparam int IDB = 40;

    typedef struct {
        logic [IDB-1:0] s;
        logic [IDB-1:0] e;
        bit             last;
    } pair_t;

    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic           InValid = 1'b0;
    logic [IDB-1:0] StartId = '0;
    logic [IDB-1:0] EndId = '0;
    logic           InLast = 1'b0;

    logic        ready_b, wren_b, done_b, err_b;
    logic [15:0] addr_b;
    logic [7:0]  data_b;
    logic [16:0] len_b;
    logic        ready_s, wren_s, done_s, err_s;
    logic [15:0] addr_s;
    logic [7:0]  data_s;
    logic [16:0] len_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_viol = 0;
    bit active = 0;

    pair_t        pq[$];
    byte unsigned exp_q[$];
    bit           exp_oerr;
    int           pos_first[$];
    int           pos_dash[$];
    byte unsigned cap_b[$];
    byte unsigned cap_s[$];
    int           wcyc_b[$];
    int           acc_q[$];

    range_list_writer dut_big (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(ready_b),
        .StartId(StartId), .EndId(EndId), .InLast(InLast),
        .WrEn(wren_b), .WrAddr(addr_b), .WrData(data_b),
        .Length(len_b), .Done(done_b), .Error(err_b)
    );

    range_list_writer #(.MEM_DEPTH(8)) dut_small (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(ready_s),
        .StartId(StartId), .EndId(EndId), .InLast(InLast),
        .WrEn(wren_s), .WrAddr(addr_s), .WrData(data_s),
        .Length(len_s), .Done(done_s), .Error(err_s)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Capture every write and watch InReady while a pair is in flight
    always @(negedge Clk) begin
        if (!Rst) begin
            if (wren_b) begin
                chk("wraddr_big", addr_b, cap_b.size());
                cap_b.push_back(data_b);
                wcyc_b.push_back(cyc);
                if (data_b == 8'h2C || data_b == 8'h04) active = 0;
            end
            if (wren_s) begin
                chk("wraddr_small", addr_s, cap_s.size());
                cap_s.push_back(data_s);
            end
            if (active && ready_b) rdy_viol++;
        end
    end

    task automatic model_build();
        string t;
        exp_q.delete();
        pos_first.delete();
        pos_dash.delete();
        exp_oerr = 0;
        for (int k = 0; k < pq.size(); k++) begin
`ifdef RANGE_LIST_WRITER_ORDER_CHECK_EN
            if (pq[k].s > pq[k].e) begin
                exp_oerr = 1;
                break;
            end
`endif
            pos_first.push_back(exp_q.size());
            t = $sformatf("%0d", pq[k].s);
            for (int i = 0; i < t.len(); i++) exp_q.push_back(t[i]);
            pos_dash.push_back(exp_q.size());
            exp_q.push_back(8'h2D);
            t = $sformatf("%0d", pq[k].e);
            for (int i = 0; i < t.len(); i++) exp_q.push_back(t[i]);
            exp_q.push_back(pq[k].last ? 8'h04 : 8'h2C);
            if (pq[k].last) break;
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        InValid = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst.InReady", ready_b, 0);
        chk("rst.WrEn", wren_b, 0);
        chk("rst.WrAddr", addr_b, 0);
        chk("rst.WrData", data_b, 0);
        chk("rst.Length", len_b, 0);
        chk("rst.Done", done_b, 0);
        chk("rst.Error", err_b | err_s, 0);
        cap_b.delete();
        cap_s.delete();
        wcyc_b.delete();
        acc_q.delete();
        active = 0;
        rdy_viol = 0;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic send_pair(input pair_t p, output bit ok);
        int n = 0;
        ok = 0;
        while (!ready_b && !err_b && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        if (err_b) return;
        if (n >= 1000) begin
            chk("ready_timeout", n, 0);
            return;
        end
        InValid = 1'b1;
        StartId = p.s;
        EndId = p.e;
        InLast = p.last;
        @(posedge Clk);
        #1;
        acc_q.push_back(cyc);
        active = 1;
        @(negedge Clk);
        InValid = 1'b0;
        StartId = {8'($urandom), $urandom};
        EndId = {8'($urandom), $urandom};
        InLast = 1'($urandom);
        ok = 1;
    endtask

    task automatic drive_pairs();
        int n = 0;
        bit ok;
        for (int k = 0; k < pq.size(); k++) begin
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            send_pair(pq[k], ok);
            if (!ok) break;
        end
        while (!((done_b || err_b) && (done_s || err_s)) && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 3000) chk("finish_timeout", n, 0);
        repeat (3) @(negedge Clk);
    endtask

    task automatic check_dut(input string nm, input int depth, input bit sel);
        int n;
        int got;
        bit err;
        n = (exp_q.size() > depth) ? depth : exp_q.size();
        err = exp_oerr || (exp_q.size() > depth);
        got = sel ? cap_s.size() : cap_b.size();
        chk({nm, ".nbytes"}, got, n);
        for (int i = 0; i < n && i < got; i++) begin
            chk({nm, ".byte"}, sel ? cap_s[i] : cap_b[i], exp_q[i]);
        end
        chk({nm, ".Length"}, sel ? len_s : len_b, n);
        chk({nm, ".Done"}, sel ? done_s : done_b, !err);
        chk({nm, ".Error"}, sel ? err_s : err_b, err);
        chk({nm, ".InReady"}, sel ? ready_s : ready_b, 0);
    endtask

    task automatic run_case(input string nm);
        model_build();
        do_reset();
        drive_pairs();
        check_dut({nm, ".big"}, 65536, 1'b0);
        check_dut({nm, ".small"}, 8, 1'b1);
        for (int k = 0; k < acc_q.size() && k < pos_first.size(); k++) begin
            if (pos_first[k] < wcyc_b.size())
                chk({nm, ".lat_start"}, wcyc_b[pos_first[k]] - acc_q[k], IDB + 1);
            if (pos_dash[k] + 1 < wcyc_b.size())
                chk({nm, ".lat_end"},
                    wcyc_b[pos_dash[k] + 1] - wcyc_b[pos_dash[k]], IDB + 1);
        end
        chk({nm, ".ready_busy"}, rdy_viol, 0);
    endtask

    function automatic logic [IDB-1:0] rnd_id();
        logic [IDB-1:0] v;
        case ($urandom_range(0, 3))
            0: v = IDB'($urandom_range(0, 9));
            1: v = IDB'($urandom_range(0, 99999));
            2: v = {8'($urandom), $urandom};
            default: v = '1;
        endcase
        return v;
    endfunction

    initial begin
        int n;
        bit ok;

        pq = '{};
        pq.push_back('{40'd11, 40'd22, 1'b0});
        pq.push_back('{40'd95, 40'd115, 1'b1});
        run_case("two_pairs");

        pq = '{};
        pq.push_back('{40'd0, 40'd0, 1'b1});
        run_case("zeros");

        pq = '{};
        pq.push_back('{40'd1099511627775, 40'd1099511627775, 1'b1});
        run_case("max_ids");

        pq = '{};
        pq.push_back('{40'd1234, 40'd5678, 1'b1});
        run_case("overflow8");

        pq = '{};
        pq.push_back('{40'd50, 40'd40, 1'b1});
        run_case("order");

        // Reset while the end ID is being emitted
        pq = '{};
        pq.push_back('{40'd123456, 40'd7890123, 1'b1});
        do_reset();
        send_pair(pq[0], ok);
        n = 0;
        while (cap_b.size() < 8 && n < 500) begin
            @(negedge Clk);
            #1;
            n++;
        end
        chk("midrst.reached", cap_b.size(), 8);
        #1;
        Rst = 1'b1;
        #1;
        chk("midrst.WrEn", wren_b, 0);
        chk("midrst.WrAddr", addr_b, 0);
        chk("midrst.WrData", data_b, 0);
        chk("midrst.Length", len_b, 0);
        chk("midrst.InReady", ready_b, 0);
        chk("midrst.Done", done_b, 0);
        chk("midrst.Error", err_b, 0);
        chk("midrst.small_len", len_s, 0);

        pq = '{};
        pq.push_back('{40'd3, 40'd4, 1'b1});
        run_case("after_rst");

        for (int r = 0; r < 6; r++) begin
            int np;
            np = $urandom_range(1, 3);
            pq = '{};
            for (int k = 0; k < np; k++) begin
                pq.push_back('{rnd_id(), rnd_id(), (k == np - 1)});
            end
            run_case($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
